fruta_gen: RTL

- Fruit-position source directly upstream of the game-update FSM.
- Always holds a published free cell `(fruta_wx, fruta_wy)` on the 40x30 map.
- On a `fruta_enable` pulse it keeps the published cell stable, then searches for the next free cell. The search draws random candidates from a free-running LFSR and checks each one against the map memory through a read port.
- Only cells whose map code is 2'b00 (empty) are accepted.

---
 rtl/fruta_pkg.sv | 30 +++
 rtl/lfsr16.sv | 20 ++
 rtl/fruta_gen.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fruta_pkg.sv
// Shared definitions for the fruit generator: map cell codes, FSM states,
// LFSR taps and default map dimensions.
package fruta_pkg;

  typedef enum logic [1:0] {
    VAZIO     = 2'b00,
    COBRA     = 2'b01,
    FRUTA     = 2'b10,
    OBSTACULO = 2'b11
  } cell_e;

  typedef enum logic [2:0] {
    StReady,
    StDraw,
    StAddr,
    StCheck,
    StScan,
    StFull
  } fruta_state_e;

  localparam logic [15:0] LfsrTaps      = 16'hB400;
  localparam int unsigned MapaWidthDef  = 40;
  localparam int unsigned MapaHeightDef = 30;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LfsrTaps) : (v >> 1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; a zero seed is replaced by 1 so the
// register can never lock up.
module lfsr16
  import fruta_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= (seed == 16'h0000) ? 16'h0001 : seed;
    end else begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/fruta_gen.sv
// Fruit position generator: publishes a free map cell and, on request, searches
// for the next one with random draws. Optional fallback scan: FRUTA_FALLBACK_SCAN_EN.
module fruta_gen
  import fruta_pkg::*;
#(
  parameter int unsigned MAPA_WIDTH  = MapaWidthDef,
  parameter int unsigned MAPA_HEIGHT = MapaHeightDef,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int unsigned FRUTA_X0    = 13,
  parameter int unsigned FRUTA_Y0    = 13,
  parameter int unsigned MAX_TRIES   = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fruta_enable,
  output logic       fruta_wenable,
  output logic [9:0] fruta_wx,
  output logic [9:0] fruta_wy,
  output logic       fruta_renable,
  output logic [9:0] fruta_rx,
  output logic [9:0] fruta_ry,
  input  logic [1:0] fruta_rdata,
  output logic       fruta_busy
);

  fruta_state_e state_q, state_d;
  logic [15:0]  lfsr;
  logic [9:0]   cx, cy;
  logic [9:0]   wx_d, wy_d, rx_d, ry_d;
  logic         wen_d, ren_d, busy_d;
  logic [6:0]   tries_q, tries_d, tries_inc;
  logic         accept;
  logic         unused_lfsr;

  lfsr16 u_lfsr (
    .clk  (clk),
    .reset(reset),
    .seed (LFSR_SEED),
    .q    (lfsr)
  );

  assign cx          = {4'b0000, lfsr[5:0]};
  assign cy          = {5'b00000, lfsr[12:8]};
  assign unused_lfsr = ^{lfsr[15:13], lfsr[7:6]};
  assign tries_inc   = (tries_q == 7'h7F) ? tries_q : tries_q + 7'd1;

  // Also reject the still-published cell: the map write of the old fruit may be in flight.
  assign accept = (fruta_rdata == VAZIO) && !((fruta_rx == fruta_wx) && (fruta_ry == fruta_wy));

`ifdef FRUTA_FALLBACK_SCAN_EN
  logic [9:0] scan_x_q, scan_x_d, scan_y_q, scan_y_d;
  logic       scan_q, scan_d;
  logic       scan_last;

  assign scan_last = (scan_x_q == 10'(MAPA_WIDTH - 1)) && (scan_y_q == 10'(MAPA_HEIGHT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_q   <= 1'b0;
      scan_x_q <= '0;
      scan_y_q <= '0;
    end else begin
      scan_q   <= scan_d;
      scan_x_q <= scan_x_d;
      scan_y_q <= scan_y_d;
    end
  end
`else
  localparam int unsigned unused_max_tries = MAX_TRIES;
`endif

  always_comb begin
    state_d = state_q;
    wx_d    = fruta_wx;
    wy_d    = fruta_wy;
    rx_d    = fruta_rx;
    ry_d    = fruta_ry;
    wen_d   = fruta_wenable;
    busy_d  = fruta_busy;
    ren_d   = 1'b0;
    tries_d = tries_q;
`ifdef FRUTA_FALLBACK_SCAN_EN
    scan_d   = scan_q;
    scan_x_d = scan_x_q;
    scan_y_d = scan_y_q;
`endif
    unique case (state_q)
      StReady: begin
        if (fruta_enable) begin
          wen_d   = 1'b0;
          busy_d  = 1'b1;
          tries_d = '0;
          state_d = StDraw;
`ifdef FRUTA_FALLBACK_SCAN_EN
          scan_d  = 1'b0;
`endif
        end
      end
      StDraw: begin
`ifdef FRUTA_FALLBACK_SCAN_EN
        if (tries_q >= 7'(MAX_TRIES)) begin
          state_d  = StScan;
          scan_d   = 1'b1;
          scan_x_d = '0;
          scan_y_d = '0;
        end else
`endif
        if ((cx >= 10'(MAPA_WIDTH)) || (cy >= 10'(MAPA_HEIGHT))) begin
          tries_d = tries_inc;
        end else begin
          rx_d    = cx;
          ry_d    = cy;
          ren_d   = 1'b1;
          state_d = StAddr;
        end
      end
      StAddr: begin
        state_d = StCheck;
      end
      StCheck: begin
        if (accept) begin
          wx_d    = fruta_rx;
          wy_d    = fruta_ry;
          wen_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = StReady;
        end else begin
          tries_d = tries_inc;
          state_d = StDraw;
`ifdef FRUTA_FALLBACK_SCAN_EN
          if (scan_q) begin
            if (scan_last) begin
              wen_d   = 1'b0;
              busy_d  = 1'b0;
              state_d = StFull;
            end else begin
              state_d = StScan;
              if (scan_x_q == 10'(MAPA_WIDTH - 1)) begin
                scan_x_d = '0;
                scan_y_d = scan_y_q + 10'd1;
              end else begin
                scan_x_d = scan_x_q + 10'd1;
              end
            end
          end
`endif
        end
      end
`ifdef FRUTA_FALLBACK_SCAN_EN
      StScan: begin
        rx_d    = scan_x_q;
        ry_d    = scan_y_q;
        ren_d   = 1'b1;
        state_d = StAddr;
      end
      StFull: begin
        // Map exhausted: hold until reset.
      end
`endif
      default: begin
        state_d = StReady;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StReady;
      fruta_wx      <= 10'(FRUTA_X0);
      fruta_wy      <= 10'(FRUTA_Y0);
      fruta_wenable <= 1'b1;
      fruta_busy    <= 1'b0;
      fruta_renable <= 1'b0;
      fruta_rx      <= '0;
      fruta_ry      <= '0;
      tries_q       <= '0;
    end else begin
      state_q       <= state_d;
      fruta_wx      <= wx_d;
      fruta_wy      <= wy_d;
      fruta_wenable <= wen_d;
      fruta_busy    <= busy_d;
      fruta_renable <= ren_d;
      fruta_rx      <= rx_d;
      fruta_ry      <= ry_d;
      tries_q       <= tries_d;
    end
  end

endmodule
